instr_fetch_unit: RTL and testbench

//  Instruction producer for the core's decode/control stage: owns the PC, issues word reads to

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, buffers returned words for decode.
// Optional IFU_PERF_CNT_EN adds Perf_Fetched / Perf_Stall counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction,
  output logic [31:0] Instr_PC,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  input  logic        PC_Sel,
  input  logic [31:0] Branch_Target,
  input  logic        Clk_Enable
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Stall
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d, rpc_q, rpc_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d, infl_q, infl_d, drop_q, drop_d;
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic          issue, accept, redir, push, pop;
  logic [31:0]   tgt;
  logic          unused_bt;

  assign tgt       = {Branch_Target[31:2], 2'b00};
  assign unused_bt = ^Branch_Target[1:0];

  // Credit counts both buffered words and reads still in flight, so every response has a slot.
  assign Imem_Req    = !Rst && Clk_Enable &&
                       (((CW+1)'(cnt_q) + (CW+1)'(infl_q)) < (CW+1)'(BUF_DEPTH));
  assign Imem_Addr   = pc_q;
  assign Instr_Valid = (cnt_q != '0);
  assign Instruction = buf_instr_q[rptr_q];
  assign Instr_PC    = buf_pc_q[rptr_q];

  always_comb begin
    issue  = Imem_Req && Imem_Ready;
    accept = Instr_Valid && Instr_Ready;
    redir  = accept && PC_Sel;
    push   = Imem_Rvalid && !redir && (drop_q == '0);
    pop    = accept && !redir;
    infl_d = infl_q + CW'(issue) - CW'(Imem_Rvalid);
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (redir) begin
      // Everything still outstanding after this edge, including a coincident issue, is stale.
      pc_d   = tgt;
      rpc_d  = tgt;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      drop_d = infl_d;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (Imem_Rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        rpc_d  = rpc_q + 32'd4;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q   <= RESET_VECTOR;
      rpc_q  <= RESET_VECTOR;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else if (push) begin
      buf_instr_q[wptr_q] <= Imem_Rdata;
      buf_pc_q[wptr_q]    <= rpc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (accept)                     fetched_q <= fetched_q + 32'd1;
      if (!Instr_Valid && Clk_Enable) stall_q   <= stall_q + 32'd1;
    end
  end

  assign Perf_Fetched = fetched_q;
  assign Perf_Stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: in-order 1-cycle memory model, expected PCs queued
// by directed tests, accepted instructions checked by an independent monitor.
module tb_instr_fetch_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Imem_Req, Imem_Ready, Imem_Rvalid;
  logic [31:0] Imem_Addr, Imem_Rdata;
  logic [31:0] Instruction, Instr_PC, Branch_Target;
  logic        Instr_Valid, Instr_Ready, PC_Sel, Clk_Enable;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] Perf_Fetched, Perf_Stall;
  int          stall_cnt = 0;
`endif

  int          tests = 0, fails = 0;
  logic        rdy_en = 1'b1, rsp_en = 1'b1;
  logic [31:0] memq[$], issued[$], sb[$];

  instr_fetch_unit #(.RESET_VECTOR(32'h0), .BUF_DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ready(Imem_Ready),
    .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
    .Instruction(Instruction), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready), .PC_Sel(PC_Sel), .Branch_Target(Branch_Target),
    .Clk_Enable(Clk_Enable)
`ifdef IFU_PERF_CNT_EN
    , .Perf_Fetched(Perf_Fetched), .Perf_Stall(Perf_Stall)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: drives response/ready shortly after negedge, records issues just before posedge.
  initial begin
    Imem_Ready = 1'b0; Imem_Rvalid = 1'b0; Imem_Rdata = '0;
    forever begin
      @(negedge Clk); #1;
      if (!Rst && rsp_en && memq.size() > 0) begin
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = mdata(memq.pop_front());
      end else begin
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = '0;
      end
      Imem_Ready = rdy_en;
      #3;
      if (!Rst && Imem_Req && Imem_Ready) begin
        memq.push_back(Imem_Addr);
        issued.push_back(Imem_Addr);
      end
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clk); #4;
`ifdef IFU_PERF_CNT_EN
      if (!Rst && !Instr_Valid && Clk_Enable) stall_cnt++;
`endif
      if (!Rst && Instr_Valid && Instr_Ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_accept: got pc %h, expected no accept", Instr_PC);
        end else begin
          e = sb.pop_front();
          chk("accept_pc", Instr_PC, e);
          chk("accept_instr", Instruction, mdata(e));
        end
      end
    end
  end

  task automatic do_reset();
    Rst = 1'b1; rdy_en = 1'b1; rsp_en = 1'b1; Instr_Ready = 1'b0; PC_Sel = 1'b0;
    Branch_Target = '0; Clk_Enable = 1'b1;
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL leftover_expect: got %0d pending, expected 0", sb.size());
    end
    sb.delete(); memq.delete(); issued.delete();
    repeat (2) @(negedge Clk);
    chk("rst_req", 32'(Imem_Req), 32'd0);
    chk("rst_valid", 32'(Instr_Valid), 32'd0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc", Instr_PC, 32'h0);
    chk("rst_addr", Imem_Addr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetched", Perf_Fetched, 32'h0);
    chk("rst_perf_stall", Perf_Stall, 32'h0);
    stall_cnt = 0;
`endif
    Rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    Instr_Ready = 1'b0;
  endtask

  task automatic redirect_test(input logic [31:0] at, input logic [31:0] target,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    int n = 0;
    do_reset();
    for (logic [31:0] p = 0; p <= at; p += 4) sb.push_back(p);
    sb.push_back(e0); sb.push_back(e1); sb.push_back(e2);
    Instr_Ready = 1'b1;
    while (!(Instr_Valid && Instr_PC == at) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("redir_head_seen", Instr_PC, at);
    // Hold responses so stale reads return after the flush and must be dropped.
    PC_Sel = 1'b1; Branch_Target = target; rsp_en = 1'b0;
    @(negedge Clk);
    PC_Sel = 1'b0; Branch_Target = '0;
    repeat (2) @(negedge Clk);
    rsp_en = 1'b1;
    drain(60);
  endtask

  initial begin
    int n;
    // 1-cycle memory stream, then Ready held low at 0x10.
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    Instr_Ready = 1'b1;
    n = 0;
    while (Imem_Addr != 32'h10 && n < 40) begin @(negedge Clk); n++; end
    rdy_en = 1'b0;
    n = 0;
    while (!Imem_Req && n < 10) begin @(negedge Clk); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(Imem_Req), 32'd1);
      chk("stall_addr", Imem_Addr, 32'h10);
      @(negedge Clk);
    end
    chk("stall_issued", 32'(issued.size()), 32'd4);
    rdy_en = 1'b1;
    sb.push_back(32'h10); sb.push_back(32'h14); sb.push_back(32'h18);
    drain(60);

    // Redirect at 0x8 to 0x103, and a redirect that crosses the address wrap.
    redirect_test(32'h8, 32'h103, 32'h100, 32'h104, 32'h108);
    redirect_test(32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);

    // Decode back-pressure: buffer fills at 2 words, then resumes in order.
    do_reset();
    repeat (6) @(negedge Clk);
    chk("bp_req", 32'(Imem_Req), 32'd0);
    chk("bp_issued", 32'(issued.size()), 32'd2);
    chk("bp_valid", 32'(Instr_Valid), 32'd1);
    chk("bp_head_pc", Instr_PC, 32'h0);
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    Instr_Ready = 1'b1;
    drain(60);

    // Halt with one read in flight.
    do_reset();
    rsp_en = 1'b0;
    n = 0;
    while (issued.size() < 1 && n < 20) begin @(negedge Clk); n++; end
    Clk_Enable = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("halt_req", 32'(Imem_Req), 32'd0);
    end
    chk("halt_issued", 32'(issued.size()), 32'd1);
    chk("halt_valid", 32'(Instr_Valid), 32'd1);
    chk("halt_head_pc", Instr_PC, 32'h0);
    Clk_Enable = 1'b1; Instr_Ready = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    drain(60);
    chk("halt_resume_addr", (issued.size() > 1) ? issued[1] : 32'hDEAD_DEAD, 32'h4);

`ifdef IFU_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) sb.push_back(32'(i * 4));
    Instr_Ready = 1'b1;
    drain(100);
    Clk_Enable = 1'b0;
    @(negedge Clk);
    chk("perf_fetched", Perf_Fetched, 32'd10);
    chk("perf_stall", Perf_Stall, 32'(stall_cnt));
`endif

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
